// File: rtl/ro_freq_counter_pkg.sv
// ro_pkg: shared FSM state type, default sizing and gate-counter width helper for ro_freq_counter.
package ro_pkg;
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} ro_state_t;
  localparam int RO_GATE_CYCLES_DFLT = 4096;
  localparam int RO_CNT_W_DFLT = 16;
  function automatic int ro_gate_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ro_freq_counter_if.sv
// ro_freq_counter_if: host-side request/result bundle of the ring-oscillator frequency counter.
interface ro_freq_counter_if import ro_pkg::*; #(parameter int CNT_W = RO_CNT_W_DFLT);
  logic start;
  logic byte_sel;
  logic [7:0] result_byte;
  logic [CNT_W-1:0] result;
  logic busy;
  logic done;
  logic ovf;
  modport master(output start, byte_sel, input result_byte, result, busy, done, ovf);
  modport slave(input start, byte_sel, output result_byte, result, busy, done, ovf);
endinterface

// File: rtl/ro_freq_counter_sync_edge.sv
// ro_sync_edge: 2-FF synchronizer plus edge-detect flop; pulses one clk cycle per rising edge of async_in.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[1:0], async_in};
  assign rise_pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: counts ring-oscillator edges over a GATE_CYCLES window and latches the result.
// Optional RO_FREQ_CONT_EN adds a cont input for back-to-back measurements.
module ro_freq_counter import ro_pkg::*; #(
  parameter int GATE_CYCLES = RO_GATE_CYCLES_DFLT,
  parameter int CNT_W = RO_CNT_W_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic osc_in,
`ifdef RO_FREQ_CONT_EN
  input  logic cont,
`endif
  ro_freq_counter_if.slave bus
);
  localparam int GW = ro_gate_w(GATE_CYCLES);
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  ro_state_t state;
  logic [GW-1:0] gcnt;
  logic [CNT_W-1:0] ecnt, ecnt_nx;
  logic sticky, sticky_nx, sat, rise, last, go_cont;
  logic [15:0] res16;
  ro_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .async_in(osc_in), .rise_pulse(rise));
`ifdef RO_FREQ_CONT_EN
  assign go_cont = ena & cont;
`else
  assign go_cont = 1'b0;
`endif
  assign sat = rise && ecnt == CMAX;
  assign ecnt_nx = (rise && !sat) ? ecnt + 1'b1 : ecnt;
  assign sticky_nx = sticky | sat;
  assign last = gcnt == GLAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gcnt <= '0;
      ecnt <= '0;
      sticky <= 1'b0;
      bus.result <= '0;
      bus.ovf <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (!ena) state <= IDLE;
      else
        case (state)
          IDLE: state <= bus.start ? ARM : IDLE;
          ARM: begin
            gcnt <= '0;
            ecnt <= '0;
            sticky <= 1'b0;
            state <= GATE;
          end
          GATE: begin
            ecnt <= ecnt_nx;
            sticky <= sticky_nx;
            gcnt <= last ? gcnt : gcnt + 1'b1;
            if (last) begin
              state <= DONE;
              bus.result <= ecnt_nx;
              bus.ovf <= sticky_nx;
              bus.done <= 1'b1;
            end
          end
          DONE: state <= go_cont ? ARM : IDLE;
        endcase
    end
  // busy also covers DONE when a continuous re-arm follows
  assign bus.busy = state == ARM || state == GATE || (state == DONE && go_cont);
  assign res16 = 16'(bus.result);
  assign bus.result_byte = bus.byte_sel ? res16[15:8] : res16[7:0];
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed scoreboard bench for ro_freq_counter (64-cycle/16-bit and 1024-cycle/8-bit instances).
module tb_ro_freq_counter;
  typedef struct {logic [15:0] res; logic ovf;} exp_t;
  logic clk, rst_n, ena_a, osc;
`ifdef RO_FREQ_CONT_EN
  logic cont, cont_b;
`endif
  int osc_half, oc, total, pass_cnt, fail_cnt, dones_a, dones_b, n, d0;
  logic osc_lvl;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  ro_freq_counter_if #(.CNT_W(16)) ba();
  ro_freq_counter_if #(.CNT_W(8)) bb();
  ro_freq_counter #(.GATE_CYCLES(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .osc_in(osc),
`ifdef RO_FREQ_CONT_EN
    .cont(cont),
`endif
    .bus(ba)
  );
  ro_freq_counter #(.GATE_CYCLES(1024), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .osc_in(osc),
`ifdef RO_FREQ_CONT_EN
    .cont(cont_b),
`endif
    .bus(bb)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    osc = 0;
    oc = 0;
    forever begin
      @(negedge clk);
      if (osc_half == 0) osc = osc_lvl;
      else begin
        oc++;
        if (oc >= osc_half) begin
          oc = 0;
          osc = ~osc;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ba.done === 1'b1) begin
        dones_a++;
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_result", 32'(ba.result), 32'(ea.res));
          chk("a_ovf", 32'(ba.ovf), 32'(ea.ovf));
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bb.done === 1'b1) begin
        dones_b++;
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_result", 32'(bb.result), 32'(eb.res));
          chk("b_ovf", 32'(bb.ovf), 32'(eb.ovf));
        end
      end
    end
  end
  task automatic wait_a(input bit tog, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      ba.start = tog && cnt >= 10 && cnt < 30 && cnt[0];
    end while (ba.done !== 1'b1 && cnt < 3000);
  endtask
  task automatic run_a(input bit tog, output int cnt);
    ba.start = 1;
    wait_a(tog, cnt);
  endtask
  initial begin
    total = 0; pass_cnt = 0; fail_cnt = 0; dones_a = 0; dones_b = 0;
    rst_n = 1; ena_a = 1; osc_half = 0; osc_lvl = 0;
    ba.start = 0; ba.byte_sel = 0; bb.start = 0; bb.byte_sel = 0;
`ifdef RO_FREQ_CONT_EN
    cont = 0; cont_b = 0;
`endif
    #2 rst_n = 0;
    #10;
    chk("rst_result", 32'(ba.result), 0);
    chk("rst_busy", 32'(ba.busy), 0);
    chk("rst_done", 32'(ba.done), 0);
    chk("rst_ovf", 32'(ba.ovf), 0);
    chk("rst_byte", 32'(ba.result_byte), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    // clk/4 input: 16 edges per 64-cycle window
    osc_half = 2;
    repeat (10) @(negedge clk);
    qa.push_back('{16'd16, 1'b0});
    run_a(0, n);
    chk("freq_latency", n, 66);
`ifndef RO_FREQ_CONT_EN
    chk("freq_busy_done", 32'(ba.busy), 0);
`endif
    ba.byte_sel = 0;
    #1 chk("freq_byte0", 32'(ba.result_byte), 32'h10);
    ba.byte_sel = 1;
    #1 chk("freq_byte1", 32'(ba.result_byte), 32'h00);
    ba.byte_sel = 0;
    // stuck-high input yields zero edges but still one done
    osc_half = 0; osc_lvl = 1;
    repeat (8) @(negedge clk);
    d0 = dones_a;
    qa.push_back('{16'd0, 1'b0});
    run_a(0, n);
    chk("stuck_latency", n, 66);
    repeat (20) @(negedge clk);
    chk("stuck_one_done", dones_a - d0, 1);
    // clk/8 with start toggled during GATE
    osc_half = 4;
    repeat (10) @(negedge clk);
    d0 = dones_a;
    qa.push_back('{16'd8, 1'b0});
    run_a(1, n);
    chk("toggle_latency", n, 66);
    repeat (80) @(negedge clk);
    chk("toggle_one_done", dones_a - d0, 1);
    chk("toggle_idle", 32'(ba.busy), 0);
    // ena dropped mid-GATE discards the measurement
    osc_half = 2;
    d0 = dones_a;
    ba.start = 1;
    @(negedge clk);
    ba.start = 0;
    repeat (30) @(negedge clk);
    chk("abort_busy_mid", 32'(ba.busy), 1);
    ena_a = 0;
    @(negedge clk);
    ena_a = 1;
    repeat (100) @(negedge clk);
    chk("abort_no_done", dones_a - d0, 0);
    chk("abort_result_kept", 32'(ba.result), 8);
    chk("abort_idle", 32'(ba.busy), 0);
    // asynchronous reset mid-GATE
    ba.start = 1;
    @(negedge clk);
    ba.start = 0;
    repeat (20) @(negedge clk);
    chk("rstmid_busy_before", 32'(ba.busy), 1);
    #1 rst_n = 0;
    #1;
    chk("rstmid_result", 32'(ba.result), 0);
    chk("rstmid_busy", 32'(ba.busy), 0);
    chk("rstmid_done", 32'(ba.done), 0);
    chk("rstmid_ovf", 32'(ba.ovf), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("rstmid_idle", 32'(ba.busy), 0);
    chk("rstmid_result_after", 32'(ba.result), 0);
    // clk/2 input saturates the 8-bit counter
    osc_half = 1;
    repeat (10) @(negedge clk);
    qb.push_back('{16'd255, 1'b1});
    bb.start = 1;
    n = 0;
    do begin
      @(negedge clk);
      bb.start = 0;
      n++;
    end while (bb.done !== 1'b1 && n < 3000);
    chk("ovf_latency", n, 1026);
    bb.byte_sel = 1;
    #1 chk("ovf_byte1", 32'(bb.result_byte), 0);
    bb.byte_sel = 0;
    #1 chk("ovf_byte0", 32'(bb.result_byte), 32'hff);
`ifdef RO_FREQ_CONT_EN
    osc_half = 4;
    repeat (10) @(negedge clk);
    d0 = dones_a;
    repeat (3) qa.push_back('{16'd8, 1'b0});
    cont = 1;
    run_a(0, n);
    chk("cont_first", n, 66);
    wait_a(0, n);
    chk("cont_period", n, 66);
    chk("cont_busy_done", 32'(ba.busy), 1);
    repeat (5) @(negedge clk);
    cont = 0;
    wait_a(0, n);
    chk("cont_last", n, 61);
    repeat (80) @(negedge clk);
    chk("cont_stopped", 32'(ba.busy), 0);
    chk("cont_done_count", dones_a - d0, 3);
`endif
    repeat (5) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
